// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: tracks EX/MEM/WB
// destination slots and derives stalls, flushes, redirect and EX forwarding.
module pipe_hazard_fwd (
  input  logic       use_rs,
  input  logic [4:0] rs,
  input  logic       mem_wr,
  input  logic       mem_load,
  input  logic [4:0] mem_rd,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  // MEM is the younger producer, so it wins; a load in MEM has no data yet.
  always_comb begin
    sel = 2'b00;
    if (use_rs && mem_wr && !mem_load && (mem_rd == rs)) sel = 2'b01;
    else if (wb_wr && (wb_rd == rs))                    sel = 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_wb,
  input  logic             id_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       last_evt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wb;
    logic       load;
  } slot_t;

  typedef struct packed {
    slot_t      dst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } ex_slot_t;

  typedef enum logic [1:0] {
    EVT_RUN        = 2'd0,
    EVT_LOAD_STALL = 2'd1,
    EVT_MEM_WAIT   = 2'd2,
    EVT_FLUSH      = 2'd3
  } evt_t;

  ex_slot_t ex_q, id_slot;
  slot_t    mem_q;
  logic       wb_vld, wb_reg_wb;
  logic [4:0] wb_rd;

  logic ex_wr, mem_wr, wb_wr;
  logic mem_wait, flush, load_use;
  evt_t evt;

  assign ex_wr  = ex_q.dst.valid && ex_q.dst.reg_wb && (ex_q.dst.rd != 5'd0);
  assign mem_wr = mem_q.valid && mem_q.reg_wb && (mem_q.rd != 5'd0);
  assign wb_wr  = wb_vld && wb_reg_wb && (wb_rd != 5'd0);

  always_comb begin
    id_slot.dst.valid  = id_valid;
    id_slot.dst.rd     = id_rd;
    id_slot.dst.reg_wb = id_reg_wb;
    id_slot.dst.load   = id_load;
    id_slot.rs1        = id_rs1;
    id_slot.rs2        = id_rs2;
    id_slot.use_rs1    = id_use_rs1;
    id_slot.use_rs2    = id_use_rs2;
  end

  assign mem_wait = mem_req && !mem_ready;
  assign flush    = ex_branch_taken && !mem_wait;
  assign load_use = !mem_wait && !flush && id_valid && ex_q.dst.load && ex_wr &&
                    ((id_use_rs1 && (id_rs1 == ex_q.dst.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.dst.rd)));

  always_comb begin
    evt = EVT_RUN;
    if (mem_wait)      evt = EVT_MEM_WAIT;
    else if (flush)    evt = EVT_FLUSH;
    else if (load_use) evt = EVT_LOAD_STALL;
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    redirect  = 1'b0;
    unique case (evt)
      EVT_MEM_WAIT: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end
      EVT_FLUSH: begin
        redirect = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end
      EVT_LOAD_STALL: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
      default: ;
    endcase
  end

  // One forwarding lane per EX source operand.
  logic [NUM_OPS-1:0]       op_use;
  logic [NUM_OPS-1:0][4:0]  op_rs;
  logic [NUM_OPS-1:0][1:0]  op_sel;

  assign op_use = {ex_q.use_rs2, ex_q.use_rs1};
  assign op_rs  = {ex_q.rs2, ex_q.rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    pipe_hazard_fwd u_fwd (
      .use_rs   (op_use[g]),
      .rs       (op_rs[g]),
      .mem_wr   (mem_wr),
      .mem_load (mem_q.load),
      .mem_rd   (mem_q.rd),
      .wb_wr    (wb_wr),
      .wb_rd    (wb_rd),
      .sel      (op_sel[g])
    );
  end

  assign fwd_a = op_sel[0];
  assign fwd_b = op_sel[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_vld    <= 1'b0;
      wb_rd     <= '0;
      wb_reg_wb <= 1'b0;
      last_evt  <= EVT_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      last_evt <= evt;
      // Only a memory wait freezes the slots; every other event advances them.
      if (evt != EVT_MEM_WAIT) begin
        wb_vld    <= mem_q.valid;
        wb_rd     <= mem_q.rd;
        wb_reg_wb <= mem_q.reg_wb;
        mem_q     <= ex_q.dst;
        ex_q      <= (evt == EVT_RUN) ? id_slot : '0;
      end
      if ((evt == EVT_MEM_WAIT || evt == EVT_LOAD_STALL) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((evt == EVT_FLUSH) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It tracks the destination registers of the instructions in EX, MEM and WB. From that state it generates:
- the stall and flush signals for the pipeline registers,
- the operand forwarding selects for the EX-stage ALU,
- the PC redirect on a taken branch.

It sits beside the decode controller, takes decoded fields from ID plus status from EX and data memory, and is the only block that gates pipeline-register enables.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register indices of the ID instruction.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
- id_rd  in  5  destination register of the ID instruction.
- id_reg_wb  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load (WB_sel = 1).
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  MEM-stage instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_if, stall_id  out  1 each  hold PC and the IF/ID register.
- stall_ex, stall_mem  out  1 each  hold the ID/EX and EX/MEM registers.
- flush_id  out  1  IF/ID loads a bubble.
- flush_ex  out  1  ID/EX loads a bubble.
- redirect  out  1  PC loads the branch target.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage result.
- last_evt  out  2  registered: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 FLUSH.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- Internal slots EX, MEM and WB. Each slot holds {valid, rd, reg_wb, load}. The EX slot also holds {rs1, rs2, use_rs1, use_rs2}.
- A slot "writes rd" when valid && reg_wb && rd != 0. x0 is never forwarded and never causes a hazard.
- Conditions are evaluated every cycle, combinationally from the slots and the inputs.
  - mem_wait = mem_req && !mem_ready.
  - flush = ex_branch_taken && !mem_wait.
  - load_use = !mem_wait && !flush && id_valid && EX slot is a load that writes rd && ((id_use_rs1 && id_rs1 == ex.rd) || (id_use_rs2 && id_rs2 == ex.rd)).
- Priority is mem_wait > flush > load_use > run.
- MEM_WAIT:
  - stall_if, stall_id, stall_ex and stall_mem are all 1.
  - No flush and no redirect; all slots hold.
  - A pending taken branch stays in EX and is acted on the cycle mem_ready arrives.
- FLUSH:
  - redirect = flush_id = flush_ex = 1; all stalls 0.
  - Slots shift: WB <= MEM, MEM <= EX, EX <= bubble.
- LOAD_STALL:
  - stall_if = stall_id = 1 and flush_ex = 1.
  - Slots shift with EX <= bubble; the ID instruction is re-evaluated next cycle.
- RUN:
  - All stall and flush outputs are 0.
  - Slots shift with EX <= ID fields, valid = id_valid.
- Forwarding, from the EX slot (fwd_b is identical using rs2):
  - fwd_a = 01 if ex.use_rs1 and the MEM slot writes rd with mem.rd == ex.rs1 and MEM is not a load.
  - Otherwise fwd_a = 10 if the WB slot writes rd with wb.rd == ex.rs1.
  - Otherwise fwd_a = 00.
  - MEM takes priority over WB. fwd outputs are valid in every state.
- Counters:
  - stall_cnt increments on any cycle in MEM_WAIT or LOAD_STALL.
  - flush_cnt increments on any FLUSH cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (synchronous, active-high):
  - All slots become invalid; stall_cnt = flush_cnt = 0; last_evt = 0.
  - Consequently every stall, flush and redirect output is 0 and fwd_a = fwd_b = 00 in the cycle after reset is sampled.
- Reset asserted mid-operation (e.g. during MEM_WAIT) discards all slots regardless of mem_ready.
- Stall, flush, redirect and fwd outputs are combinational: zero-cycle latency from inputs and slots.
- last_evt updates at the edge ending the cycle, to that cycle's condition.
- Load-use costs exactly one bubble. The consumer then reaches EX with fwd = 10 from the load in WB.
- A taken branch costs two bubbles (IF/ID and ID/EX squashed).
- Simultaneous load_use and flush: flush wins, and the stalled consumer is itself squashed.
- Back-to-back MEM_WAIT cycles hold indefinitely. stall_cnt counts every waited cycle.

## Test plan
- ALU dependency chain: add x5 in EX, dependent add reading x5 in ID.
  - Next cycle: fwd_a = 01. The cycle after: an instruction reading x5 gets fwd_b = 10.
  - No stalls throughout; last_evt stays 0.
- Load-use: lw x6 in EX, consumer with id_rs2 = 6 in ID.
  - One cycle with stall_if = stall_id = flush_ex = 1; stall_cnt goes 0 -> 1.
  - Then the consumer in EX has fwd_b = 10. A write to x0 never triggers a stall or forward.
- Taken branch: ex_branch_taken = 1.
  - redirect = flush_id = flush_ex = 1 for one cycle; flush_cnt = 1.
  - Same cycle, a load-use condition is also present: no stall_id.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, with ex_branch_taken = 1.
  - All four stalls are 1 and redirect = 0 for 3 cycles.
  - On the 4th cycle (mem_ready = 1): redirect = 1. stall_cnt = 3.
- Saturation with CNT_W = 4: 20 load-use stalls -> stall_cnt = 15 and holds.
- Reset asserted during MEM_WAIT -> next cycle all outputs 0, counters 0, fwd = 00.
